// File: rtl/cart_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : cart_loader_if
// Brief   : Toggle req/ack SDRAM write port between cart_loader and sdram.
// Revision: 1.0
// ============================================================================
interface cart_loader_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
);
    localparam int c_wb = DATA_W / 8;
    localparam int c_wa = ADDR_W - $clog2(c_wb);

    logic [c_wa-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [c_wb-1:0]   mem_be;
    logic              mem_req;
    logic              mem_ack;

    modport master (output mem_addr, mem_wdata, mem_be, mem_req, input mem_ack);
    modport slave  (input mem_addr, mem_wdata, mem_be, mem_req, output mem_ack);
endinterface
`default_nettype wire

// File: rtl/cart_loader.sv
`default_nettype none
// ============================================================================
// Module  : cart_loader
// Brief   : Packs the iosys ROM byte stream into SDRAM words through a FIFO,
//           captures rom_size and holds core_on low until all writes complete.
//           Optional CART_LOADER_CHECKSUM_EN adds the MD header checksum port.
// Revision: 1.0
// ============================================================================
module cart_loader #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int BIG_ENDIAN = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [2:0]        loading,
    input  logic [7:0]        loader_do,
    input  logic              loader_do_valid,
    cart_loader_if.master     mem,
    output logic [ADDR_W:0]   rom_size,
    output logic              core_on,
    output logic              busy,
    output logic              overflow
`ifdef CART_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);
    localparam int c_wb = DATA_W / 8;
    localparam int c_lb = $clog2(c_wb);
    localparam int c_wa = ADDR_W - c_lb;
    localparam int c_pw = $clog2(FIFO_DEPTH);
    localparam logic [c_pw:0] c_depth = (c_pw + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_loading_act;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_wrap;
    logic [DATA_W-1:0] r_pack_data;
    logic [c_wb-1:0]   r_pack_be;
    logic              r_push_vld;
    logic [c_wa-1:0]   r_push_addr;
    logic [DATA_W-1:0] r_push_data;
    logic [c_wb-1:0]   r_push_be;
    logic [c_wa-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_wb-1:0]   r_fifo_be   [FIFO_DEPTH];
    logic [c_pw-1:0]   r_wr_ptr;
    logic [c_pw-1:0]   r_rd_ptr;
    logic [c_pw:0]     r_count;
    logic              r_req;
    logic              r_inflight;

    logic              w_active, w_start, w_end, w_byte_ok, w_word_done;
    logic              w_empty, w_full, w_pop, w_fifo_wr, w_drop, w_issue;
    logic [c_lb-1:0]   w_lane;
    logic [DATA_W-1:0] w_pack_data;
    logic [c_wb-1:0]   w_pack_be;

    assign w_active    = |loading;
    assign w_start     = w_active & ~r_loading_act;
    assign w_end       = ~w_active & r_loading_act;
    assign w_byte_ok   = (r_state == S_LOAD) && loader_do_valid;
    assign w_word_done = w_byte_ok && (&r_cnt[c_lb-1:0]);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_depth);
    // The slot stays at the head while in flight; it is released by the ack.
    assign w_pop       = r_inflight && (r_req == mem.mem_ack);
    assign w_fifo_wr   = r_push_vld && (!w_full || w_pop);
    assign w_drop      = r_push_vld && w_full && !w_pop;
    assign w_issue     = !r_inflight && (r_req == mem.mem_ack) && !w_empty;
    assign mem.mem_req = r_req;
    assign busy        = (r_state != S_IDLE) || !w_empty || (r_req != mem.mem_ack);

    always_comb begin
        w_lane      = r_cnt[c_lb-1:0];
        if (BIG_ENDIAN != 0) begin
            w_lane = ~r_cnt[c_lb-1:0];
        end
        w_pack_data = r_pack_data;
        w_pack_be   = r_pack_be;
        if (w_byte_ok) begin
            w_pack_data[{w_lane, 3'b000} +: 8] = loader_do;
            w_pack_be[w_lane]                  = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_fifo_wr) begin
            r_fifo_addr[r_wr_ptr] <= r_push_addr;
            r_fifo_data[r_wr_ptr] <= r_push_data;
            r_fifo_be[r_wr_ptr]   <= r_push_be;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_loading_act <= 1'b0;
            r_cnt         <= '0;
            r_wrap        <= 1'b0;
            r_pack_data   <= '0;
            r_pack_be     <= '0;
            r_push_vld    <= 1'b0;
            r_push_addr   <= '0;
            r_push_data   <= '0;
            r_push_be     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_req         <= 1'b0;
            r_inflight    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
            rom_size      <= '0;
            core_on       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            r_loading_act <= w_active;
            r_push_vld    <= 1'b0;

            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_drop)    overflow <= 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_inflight <= 1'b0;
            end
            r_count <= r_count + {{c_pw{1'b0}}, w_fifo_wr} - {{c_pw{1'b0}}, w_pop};
            if (w_issue) begin
                mem.mem_addr  <= r_fifo_addr[r_rd_ptr];
                mem.mem_wdata <= r_fifo_data[r_rd_ptr];
                mem.mem_be    <= r_fifo_be[r_rd_ptr];
                r_req         <= ~r_req;
                r_inflight    <= 1'b1;
            end

            case (r_state)
                S_LOAD: begin
                    if (w_byte_ok) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) begin
                            r_wrap   <= 1'b1;
                            overflow <= 1'b1;
                        end
                        if (w_word_done) begin
                            r_push_vld  <= 1'b1;
                            r_push_addr <= r_cnt[ADDR_W-1:c_lb];
                            r_push_data <= w_pack_data;
                            r_push_be   <= w_pack_be;
                            r_pack_data <= '0;
                            r_pack_be   <= '0;
                        end else begin
                            r_pack_data <= w_pack_data;
                            r_pack_be   <= w_pack_be;
                        end
                    end
                    if (w_end) r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (|r_pack_be) begin
                        r_push_vld  <= 1'b1;
                        r_push_addr <= r_cnt[ADDR_W-1:c_lb];
                        r_push_data <= r_pack_data;
                        r_push_be   <= r_pack_be;
                    end
                    r_pack_data <= '0;
                    r_pack_be   <= '0;
                    rom_size    <= r_wrap ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, r_cnt};
                    r_state     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!r_push_vld && w_empty && !r_inflight && (r_req == mem.mem_ack)) begin
                        core_on <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase

            // A new session overrides everything, but an outstanding request
            // still blocks issue until its ack returns (r_req != mem_ack).
            if (w_start) begin
                r_state     <= S_LOAD;
                core_on     <= 1'b0;
                overflow    <= 1'b0;
                r_cnt       <= '0;
                r_wrap      <= 1'b0;
                r_pack_data <= '0;
                r_pack_be   <= '0;
                r_push_vld  <= 1'b0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_inflight  <= 1'b0;
            end
        end
    end

`ifdef CART_LOADER_CHECKSUM_EN
    logic [15:0] r_csum;
    logic [7:0]  r_csum_hi;
    logic        r_csum_odd;

    assign checksum = r_csum;

    // Sum of big-endian 16-bit words from byte offset 0x200 onward.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_csum     <= '0;
            r_csum_hi  <= '0;
            r_csum_odd <= 1'b0;
        end else if (w_start) begin
            r_csum     <= '0;
            r_csum_hi  <= '0;
            r_csum_odd <= 1'b0;
        end else if (w_byte_ok && (|r_cnt[ADDR_W-1:9])) begin
            if (!r_cnt[0]) begin
                r_csum_hi  <= loader_do;
                r_csum_odd <= 1'b1;
            end else begin
                r_csum     <= r_csum + {r_csum_hi, loader_do};
                r_csum_odd <= 1'b0;
            end
        end else if ((r_state == S_FLUSH) && r_csum_odd) begin
            r_csum     <= r_csum + {r_csum_hi, 8'h00};
            r_csum_odd <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cart_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_cart_loader
// Brief   : Directed bench: 16-bit big-endian and 32-bit little-endian loaders
//           sharing one byte stream, each with its own toggle-ack SDRAM model.
// Revision: 1.0
// ============================================================================
module tb_cart_loader;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [2:0]  loading;
    logic [7:0]  loader_do;
    logic        loader_do_valid;
    logic [22:0] rom_size_a, rom_size_b;
    logic        core_on_a, core_on_b, busy_a, busy_b, overflow_a, overflow_b;
    logic        ack_a, ack_b, hold_a;
`ifdef CART_LOADER_CHECKSUM_EN
    logic [15:0] csum_a, csum_b;
`endif

    wr_t         log_a[$];
    wr_t         log_b[$];
    logic [7:0]  bytes_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        req_saved;

    always #5 clk_sys = ~clk_sys;

    cart_loader_if #(.ADDR_W(22), .DATA_W(16)) ifa ();
    cart_loader_if #(.ADDR_W(22), .DATA_W(32)) ifb ();
    assign ifa.mem_ack = ack_a;
    assign ifb.mem_ack = ack_b;

    cart_loader #(.ADDR_W(22), .DATA_W(16), .BIG_ENDIAN(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk_sys(clk_sys), .reset(reset), .loading(loading), .loader_do(loader_do),
        .loader_do_valid(loader_do_valid), .mem(ifa), .rom_size(rom_size_a),
        .core_on(core_on_a), .busy(busy_a), .overflow(overflow_a)
`ifdef CART_LOADER_CHECKSUM_EN
        , .checksum(csum_a)
`endif
    );

    cart_loader #(.ADDR_W(22), .DATA_W(32), .BIG_ENDIAN(0), .FIFO_DEPTH(4)) u_dut_b (
        .clk_sys(clk_sys), .reset(reset), .loading(loading), .loader_do(loader_do),
        .loader_do_valid(loader_do_valid), .mem(ifb), .rom_size(rom_size_b),
        .core_on(core_on_b), .busy(busy_b), .overflow(overflow_b)
`ifdef CART_LOADER_CHECKSUM_EN
        , .checksum(csum_b)
`endif
    );

    // SDRAM models: acknowledge one cycle after a pending request is seen.
    always @(posedge clk_sys) begin
        if (reset) begin
            ack_a <= 1'b0;
        end else if ((ifa.mem_req != ack_a) && !hold_a) begin
            ack_a <= ~ack_a;
            log_a.push_back('{addr: 32'(ifa.mem_addr), data: 32'(ifa.mem_wdata), be: 4'(ifa.mem_be)});
        end
    end

    always @(posedge clk_sys) begin
        if (reset) begin
            ack_b <= 1'b0;
        end else if (ifb.mem_req != ack_b) begin
            ack_b <= ~ack_b;
            log_b.push_back('{addr: 32'(ifb.mem_addr), data: 32'(ifb.mem_wdata), be: 4'(ifb.mem_be)});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic run_session(input int gap, input bit last_on_edge, input bit do_end);
        loading = 3'd1;
        tick();
        for (int i = 0; i < bytes_q.size(); i++) begin
            loader_do       = bytes_q[i];
            loader_do_valid = 1'b1;
            if (last_on_edge && (i == bytes_q.size() - 1)) loading = 3'd0;
            tick();
            loader_do_valid = 1'b0;
            repeat (gap) tick();
        end
        if (do_end) begin
            loading = 3'd0;
            tick();
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!(core_on_a && core_on_b) && (n < limit)) begin
            tick();
            n++;
        end
        check("wait_done", 64'(core_on_a & core_on_b), 64'd1);
    endtask

    initial begin
        reset = 1'b1; loading = '0; loader_do = '0; loader_do_valid = 1'b0; hold_a = 1'b0;
        repeat (3) tick();
        check("rst_core_on", 64'(core_on_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_overflow", 64'(overflow_a), 64'd0);
        check("rst_rom_size", 64'(rom_size_a), 64'd0);
        check("rst_mem_req", 64'(ifa.mem_req), 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Two bytes -> one full big-endian word.
        bytes_q = '{8'h12, 8'h34};
        log_a.delete(); log_b.delete();
        run_session(0, 1'b0, 1'b1);
        wait_done(200);
        check("t1_nwr", 64'(log_a.size()), 64'd1);
        check("t1_addr", 64'(log_a[0].addr), 64'h0);
        check("t1_data", 64'(log_a[0].data), 64'h1234);
        check("t1_be", 64'(log_a[0].be), 64'h3);
        check("t1_rom_size", 64'(rom_size_a), 64'd2);
        check("t1_busy", 64'(busy_a), 64'd0);

        // Three bytes, the last one arriving on the end-edge cycle.
        bytes_q = '{8'h12, 8'h34, 8'h56};
        log_a.delete(); log_b.delete();
        run_session(1, 1'b1, 1'b0);
        wait_done(200);
        check("t2_nwr", 64'(log_a.size()), 64'd2);
        check("t2_w0_data", 64'(log_a[0].data), 64'h1234);
        check("t2_w1_addr", 64'(log_a[1].addr), 64'h1);
        check("t2_w1_hi", 64'(log_a[1].data[15:8]), 64'h56);
        check("t2_w1_be", 64'(log_a[1].be), 64'h2);
        check("t2_rom_size", 64'(rom_size_a), 64'd3);

        // 32-bit little-endian packing.
        bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        log_a.delete(); log_b.delete();
        run_session(0, 1'b0, 1'b1);
        wait_done(200);
        check("t3_nwr", 64'(log_b.size()), 64'd1);
        check("t3_addr", 64'(log_b[0].addr), 64'h0);
        check("t3_data", 64'(log_b[0].data), 64'h44332211);
        check("t3_be", 64'(log_b[0].be), 64'hf);
        check("t3_rom_size", 64'(rom_size_b), 64'd4);

        // Stalled SDRAM: 6 words into a 4-deep FIFO, two are dropped.
        bytes_q.delete();
        for (int i = 0; i < 12; i++) bytes_q.push_back(8'(8'hA0 + i));
        log_a.delete(); log_b.delete();
        hold_a = 1'b1;
        run_session(0, 1'b0, 1'b1);
        repeat (60) tick();
        check("t4_core_on_held", 64'(core_on_a), 64'd0);
        check("t4_overflow", 64'(overflow_a), 64'd1);
        check("t4_busy", 64'(busy_a), 64'd1);
        check("t4_nwr_held", 64'(log_a.size()), 64'd0);
        hold_a = 1'b0;
        wait_done(200);
        repeat (10) tick();
        check("t4_nwr", 64'(log_a.size()), 64'd4);
        check("t4_w3_addr", 64'(log_a[3].addr), 64'h3);
        check("t4_w3_data", 64'(log_a[3].data), 64'hA6A7);
        check("t4_rom_size", 64'(rom_size_a), 64'd12);
        check("t4_overflow_sticky", 64'(overflow_a), 64'd1);

        // Restart while a write is still awaiting its ack.
        bytes_q = '{8'h01, 8'h02};
        log_a.delete(); log_b.delete();
        hold_a = 1'b1;
        run_session(0, 1'b0, 1'b1);
        repeat (6) tick();
        check("t5_pending", 64'(ifa.mem_req != ack_a), 64'd1);
        req_saved = ifa.mem_req;
        bytes_q = '{8'h03, 8'h04};
        run_session(0, 1'b0, 1'b1);
        check("t5_overflow_clr", 64'(overflow_a), 64'd0);
        repeat (20) tick();
        check("t5_no_new_req", 64'(ifa.mem_req), 64'(req_saved));
        check("t5_core_on_held", 64'(core_on_a), 64'd0);
        hold_a = 1'b0;
        wait_done(200);
        check("t5_nwr", 64'(log_a.size()), 64'd2);
        check("t5_w1_data", 64'(log_a[1].data), 64'h0304);
        check("t5_w1_addr", 64'(log_a[1].addr), 64'h0);
        check("t5_rom_size", 64'(rom_size_a), 64'd2);

`ifdef CART_LOADER_CHECKSUM_EN
        bytes_q.delete();
        for (int i = 0; i < 'h204; i++) begin
            bytes_q.push_back((i == 'h201) ? 8'h01 : ((i == 'h203) ? 8'h02 : 8'h00));
        end
        log_a.delete(); log_b.delete();
        run_session(3, 1'b0, 1'b1);
        wait_done(5000);
        check("t6_csum_a", 64'(csum_a), 64'h3);
        check("t6_csum_b", 64'(csum_b), 64'h3);
        check("t6_rom_size", 64'(rom_size_a), 64'h204);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
